vec_mul_seq: RTL and testbench

Multi-cycle sequencer for the VDOT and SMUL vector operations. These opcodes are unimplemented in the single-cycle ALU. The block sits beside the ALU in the execute stage and accepts the same 256-bit operand pair (16 lanes × 16 bits) plus opcode over a valid/ready handshake. It time-multiplexes one 16×16 multiply-accumulate lane across all 16 lanes and returns a 256-bit result over a second valid/ready handshake.

---
 rtl/vec_pkg.sv | 42 ++++
 rtl/lane_mac.sv | 42 ++++
 rtl/vec_mul_seq.sv | 136 +++++++++++++
 tb/tb_vec_mul_seq.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/vec_pkg.sv
// Shared definitions for the vector execute-stage helpers: opcodes, lane geometry, FSM encoding.
// VMUL_SAT_EN selects saturating lane arithmetic; the package helper below serves that build.
package vec_pkg;

  localparam int unsigned LANES  = 16;
  localparam int unsigned LANE_W = 16;
  localparam int unsigned CNT_W  = $clog2(LANES);
  localparam int unsigned VEC_W  = LANES * LANE_W;

  localparam logic [3:0] VADD = 4'b0000;
  localparam logic [3:0] VDOT = 4'b0001;
  localparam logic [3:0] SMUL = 4'b0010;
  localparam logic [3:0] SST  = 4'b0011;
  localparam logic [3:0] VLD  = 4'b0100;
  localparam logic [3:0] VST  = 4'b0101;
  localparam logic [3:0] SLL  = 4'b0110;
  localparam logic [3:0] SLH  = 4'b0111;
  localparam logic [3:0] NOP  = 4'b1111;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_t;

  localparam logic signed [2*LANE_W-1:0] SAT_HI = 32'sd32767;
  localparam logic signed [2*LANE_W-1:0] SAT_LO = -32'sd32768;

  // Clamp a widened signed value into one signed lane.
  function automatic logic [LANE_W-1:0] sat_lane(input logic signed [2*LANE_W-1:0] v);
    logic [LANE_W-1:0] r;
    if (v > SAT_HI) begin
      r = 16'h7fff;
    end else if (v < SAT_LO) begin
      r = 16'h8000;
    end else begin
      r = v[LANE_W-1:0];
    end
    return r;
  endfunction

endpackage

// File: rtl/lane_mac.sv
// Single signed 16x16 multiply with optional accumulate, shared across all lanes.
// VMUL_SAT_EN: clamp the product and the accumulate step; otherwise wrap mod 2^16.
module lane_mac
  import vec_pkg::*;
(
  input  logic signed [LANE_W-1:0] a,
  input  logic signed [LANE_W-1:0] b,
  input  logic signed [LANE_W-1:0] acc_in,
  input  logic                     sel_acc,
  output logic        [LANE_W-1:0] y
);

`ifdef VMUL_SAT_EN
  logic signed [2*LANE_W-1:0] prod;
  logic signed [2*LANE_W-1:0] sum;
  logic signed [LANE_W-1:0]   prod_c;

  always_comb begin
    prod   = (2*LANE_W)'(a) * (2*LANE_W)'(b);
    prod_c = sat_lane(prod);
    if (sel_acc) begin
      sum = (2*LANE_W)'(prod_c) + (2*LANE_W)'(acc_in);
    end else begin
      sum = (2*LANE_W)'(prod_c);
    end
    y = sat_lane(sum);
  end
`else
  logic signed [LANE_W-1:0] prod_c;

  // Lane-width context keeps only the low half of the signed product.
  always_comb begin
    prod_c = a * b;
    if (sel_acc) begin
      y = prod_c + acc_in;
    end else begin
      y = prod_c;
    end
  end
`endif

endmodule

// File: rtl/vec_mul_seq.sv
// Multi-cycle VDOT/SMUL sequencer: one shared MAC stepped over all lanes, valid/ready on both sides.
// Arithmetic mode follows VMUL_SAT_EN through lane_mac; timing is the same in both builds.
module vec_mul_seq
  import vec_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [3:0]         opcode,
  input  logic [VEC_W-1:0]   op_1,
  input  logic [VEC_W-1:0]   op_2,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [VEC_W-1:0]   result,
  output logic               err,
  output logic               busy
);

  state_t              state_q;
  logic [CNT_W-1:0]    cnt_q;
  logic [3:0]          opc_q;
  logic [VEC_W-1:0]    op1_q;
  logic [VEC_W-1:0]    op2_q;
  logic [LANE_W-1:0]   acc_q;
  logic [VEC_W-1:0]    result_q;
  logic                err_q;
  logic                in_ready_q;
  logic                out_valid_q;
  logic                busy_q;

  int unsigned         base;
  logic                is_vdot;
  logic                is_smul;
  logic                last_lane;
  logic [LANE_W-1:0]   mac_a;
  logic [LANE_W-1:0]   mac_b;
  logic [LANE_W-1:0]   mac_y;
  logic [VEC_W-1:0]    smul_vec;

  always_comb begin
    base      = LANE_W * 32'(cnt_q);
    is_vdot   = (opc_q == VDOT);
    is_smul   = (opc_q == SMUL);
    last_lane = (cnt_q == CNT_W'(LANES - 1));
    mac_b     = op2_q[base +: LANE_W];
    mac_a     = is_smul ? op1_q[LANE_W-1:0] : op1_q[base +: LANE_W];
  end

  lane_mac u_lane_mac (
    .a       (mac_a),
    .b       (mac_b),
    .acc_in  (acc_q),
    .sel_acc (is_vdot),
    .y       (mac_y)
  );

  // SMUL products overwrite op2 lanes in place; each op2 lane is read only once, at its own step.
  always_comb begin
    smul_vec               = op2_q;
    smul_vec[base +: LANE_W] = mac_y;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      opc_q       <= '0;
      op1_q       <= '0;
      op2_q       <= '0;
      acc_q       <= '0;
      result_q    <= '0;
      err_q       <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (in_valid) begin
            opc_q      <= opcode;
            op1_q      <= op_1;
            op2_q      <= op_2;
            cnt_q      <= '0;
            acc_q      <= '0;
            in_ready_q <= 1'b0;
            busy_q     <= 1'b1;
            if (opcode == VDOT || opcode == SMUL) begin
              state_q <= RUN;
            end else begin
              state_q     <= DONE;
              result_q    <= '0;
              err_q       <= 1'b1;
              out_valid_q <= 1'b1;
            end
          end
        end
        RUN: begin
          cnt_q <= cnt_q + 1'b1;
          if (is_vdot) begin
            acc_q <= mac_y;
          end else begin
            op2_q <= smul_vec;
          end
          if (last_lane) begin
            state_q     <= DONE;
            out_valid_q <= 1'b1;
            err_q       <= 1'b0;
            result_q    <= is_vdot ? {{(VEC_W-LANE_W){1'b0}}, mac_y} : smul_vec;
          end
        end
        DONE: begin
          if (out_ready) begin
            state_q     <= IDLE;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            in_ready_q  <= 1'b1;
          end
        end
        default: begin
          state_q     <= IDLE;
          out_valid_q <= 1'b0;
          busy_q      <= 1'b0;
          in_ready_q  <= 1'b1;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign busy      = busy_q;
  assign result    = result_q;
  assign err       = err_q;

endmodule

// File: tb/tb_vec_mul_seq.sv
// Self-checking bench for vec_mul_seq: directed vector table, reset/backpressure sequences,
// and randomized operations against an arithmetic reference model (follows VMUL_SAT_EN).
module tb_vec_mul_seq;
  import vec_pkg::*;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [3:0]   opcode;
  logic [255:0] op_1;
  logic [255:0] op_2;
  logic         out_valid;
  logic         out_ready;
  logic [255:0] result;
  logic         err;
  logic         busy;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  vec_mul_seq dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .opcode    (opcode),
    .op_1      (op_1),
    .op_2      (op_2),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .err       (err),
    .busy      (busy)
  );

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic longint clampv(input longint v);
`ifdef VMUL_SAT_EN
    if (v > 32767) return 32767;
    if (v < -32768) return -32768;
`endif
    return v;
  endfunction

  function automatic longint lane_of(input logic [255:0] v, input int i);
    logic [15:0] l;
    l = v[16*i +: 16];
    return longint'($signed(l));
  endfunction

  function automatic logic [255:0] model_res(input logic [3:0] opc, input logic [255:0] a,
                                             input logic [255:0] b);
    logic [255:0] r;
    longint acc;
    r = '0;
    if (opc == 4'b0001) begin
      acc = 0;
      for (int i = 0; i < 16; i++) acc = clampv(acc + clampv(lane_of(a, i) * lane_of(b, i)));
      r[15:0] = 16'(acc);
    end else if (opc == 4'b0010) begin
      for (int i = 0; i < 16; i++) r[16*i +: 16] = 16'(clampv(lane_of(a, 0) * lane_of(b, i)));
    end
    return r;
  endfunction

  function automatic logic [255:0] rand_vec();
    logic [255:0] v;
    for (int i = 0; i < 8; i++) v[32*i +: 32] = $urandom();
    return v;
  endfunction

  task automatic run_op(input logic [3:0] opc, input logic [255:0] a, input logic [255:0] b,
                        input logic [255:0] exp_r, input logic exp_e, input int hold,
                        input string name);
    int lat;
    @(negedge clk);
    chk({name, " in_ready_idle"}, 256'(in_ready), 256'(1));
    in_valid  = 1'b1;
    opcode    = opc;
    op_1      = a;
    op_2      = b;
    out_ready = (hold == 0);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    opcode   = 4'($urandom());
    op_1     = rand_vec();
    op_2     = rand_vec();
    lat = 1;
    while (!out_valid && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    chk({name, " latency"}, 256'(lat), exp_e ? 256'(1) : 256'(17));
    chk({name, " result"}, result, exp_r);
    chk({name, " err"}, 256'(err), 256'(exp_e));
    chk({name, " busy_done"}, 256'(busy), 256'(1));
    chk({name, " in_ready_done"}, 256'(in_ready), 256'(0));
    if (hold > 0) begin
      for (int k = 0; k < hold; k++) begin
        in_valid = 1'b1;
        opcode   = 4'b0001;
        @(negedge clk);
        chk({name, " hold_valid"}, 256'(out_valid), 256'(1));
        chk({name, " hold_result"}, result, exp_r);
        chk({name, " hold_err"}, 256'(err), 256'(exp_e));
        chk({name, " hold_in_ready"}, 256'(in_ready), 256'(0));
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
    end
    @(negedge clk);
    chk({name, " valid_drop"}, 256'(out_valid), 256'(0));
    chk({name, " in_ready_back"}, 256'(in_ready), 256'(1));
    chk({name, " result_kept"}, result, exp_r);
  endtask

  typedef struct {
    logic [3:0]   opc;
    logic [255:0] a;
    logic [255:0] b;
    logic [255:0] exp_r;
    logic         exp_e;
    int           hold;
    string        name;
  } vec_t;

  vec_t tbl[7];

  initial begin
    logic [255:0] a, b, e;
    logic [3:0]   opc;

    rst       = 1'b1;
    in_valid  = 1'b0;
    opcode    = '0;
    op_1      = '0;
    op_2      = '0;
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("reset in_ready", 256'(in_ready), 256'(1));
    chk("reset out_valid", 256'(out_valid), 256'(0));
    chk("reset result", result, '0);
    chk("reset err", 256'(err), 256'(0));
    chk("reset busy", 256'(busy), 256'(0));

    for (int i = 0; i < 16; i++) begin
      tbl[0].a[16*i +: 16] = 16'd1;
      tbl[0].b[16*i +: 16] = 16'd2;
      tbl[1].a[16*i +: 16] = (i == 0) ? 16'd3 : 16'h7777;
      tbl[1].b[16*i +: 16] = 16'(i);
      tbl[1].exp_r[16*i +: 16] = 16'(3 * i);
      tbl[2].a[16*i +: 16] = 16'h4000;
      tbl[2].b[16*i +: 16] = 16'h0004;
      tbl[3].a[16*i +: 16] = 16'h8000;
      tbl[3].b[16*i +: 16] = 16'hffff;
`ifdef VMUL_SAT_EN
      tbl[3].exp_r[16*i +: 16] = 16'h7fff;
`else
      tbl[3].exp_r[16*i +: 16] = 16'h8000;
`endif
      tbl[6].a[16*i +: 16] = 16'(i);
      tbl[6].b[16*i +: 16] = 16'hffff;
    end
    tbl[0].opc = 4'b0001; tbl[0].exp_r = 256'h20; tbl[0].exp_e = 1'b0; tbl[0].hold = 0;
    tbl[0].name = "vdot_1x2";
    tbl[1].opc = 4'b0010; tbl[1].exp_e = 1'b0; tbl[1].hold = 0; tbl[1].name = "smul_3xi";
    tbl[2].opc = 4'b0001; tbl[2].exp_e = 1'b0; tbl[2].hold = 0; tbl[2].name = "vdot_ovf";
`ifdef VMUL_SAT_EN
    tbl[2].exp_r = 256'h7fff;
`else
    tbl[2].exp_r = 256'h0;
`endif
    tbl[3].opc = 4'b0010; tbl[3].exp_e = 1'b0; tbl[3].hold = 0; tbl[3].name = "smul_min";
    tbl[4].opc = 4'b0000; tbl[4].a = '1; tbl[4].b = '1; tbl[4].exp_r = '0; tbl[4].exp_e = 1'b1;
    tbl[4].hold = 0; tbl[4].name = "vadd_unsup";
    tbl[5].opc = 4'b1111; tbl[5].a = '1; tbl[5].b = '1; tbl[5].exp_r = '0; tbl[5].exp_e = 1'b1;
    tbl[5].hold = 3; tbl[5].name = "nop_unsup_bp";
    // -(0+1+...+15) = -120 = 0xff88
    tbl[6].opc = 4'b0001; tbl[6].exp_r = 256'hff88; tbl[6].exp_e = 1'b0; tbl[6].hold = 5;
    tbl[6].name = "vdot_backpressure";

    for (int t = 0; t < 7; t++) begin
      run_op(tbl[t].opc, tbl[t].a, tbl[t].b, tbl[t].exp_r, tbl[t].exp_e, tbl[t].hold,
             tbl[t].name);
    end

    // Reset while RUN is at lane 8: operation is dropped and outputs return to reset values.
    @(negedge clk);
    in_valid = 1'b1;
    opcode   = 4'b0010;
    op_1     = rand_vec();
    op_2     = rand_vec();
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (8) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midrun_rst in_ready", 256'(in_ready), 256'(1));
    chk("midrun_rst out_valid", 256'(out_valid), 256'(0));
    chk("midrun_rst result", result, '0);
    chk("midrun_rst busy", 256'(busy), 256'(0));
    repeat (20) begin
      @(negedge clk);
      chk("midrun_rst no_report", 256'(out_valid), 256'(0));
    end
    a = '0;
    for (int i = 0; i < 16; i++) a[16*i +: 16] = 16'd1;
    run_op(4'b0001, a, a, 256'h10, 1'b0, 0, "vdot_after_rst");

    for (int r = 0; r < 30; r++) begin
      case ($urandom_range(0, 4))
        0, 1:    opc = 4'b0001;
        2, 3:    opc = 4'b0010;
        default: opc = 4'($urandom_range(3, 15));
      endcase
      a = rand_vec();
      b = rand_vec();
      if ($urandom_range(0, 2) == 0) begin
        for (int i = 0; i < 16; i++) b[16*i +: 16] = 16'($urandom_range(0, 15)) - 16'd8;
      end
      e = model_res(opc, a, b);
      run_op(opc, a, b, e, (opc != 4'b0001 && opc != 4'b0010), $urandom_range(0, 2), "random");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
